// File: rtl/tick_pwm_if.sv
`default_nettype none
// ============================================================================
//  Module      : tick_pwm_if
//  Description : Signal bundle between a tick_pwm instance and its user:
//                count enable, tick source and duty request in; PWM
//                waveform, counter value and period marker out.
//  Revision    : 1.0  initial release
// ============================================================================
interface tick_pwm_if #(
    parameter int WIDTH = 8
);
    logic             CE;
    logic             tick_in;
    logic [WIDTH-1:0] duty;
    logic             pwm_out;
    logic [WIDTH-1:0] cnt;
    logic             period_end;

    // User side: drives the controls, observes the waveform.
    modport master (
        output CE,
        output tick_in,
        output duty,
        input  pwm_out,
        input  cnt,
        input  period_end
    );

    // PWM block side.
    modport slave (
        input  CE,
        input  tick_in,
        input  duty,
        output pwm_out,
        output cnt,
        output period_end
    );
endinterface
`default_nettype wire

// File: rtl/tick_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tick_pwm
//  Description : Tick-driven PWM generator. The divided clock from the
//                divider stage is sampled as data in the clk domain and
//                edge-detected into single-cycle ticks. Ticks advance a
//                period counter; the duty request is shadow-loaded at each
//                period boundary so the waveform never glitches mid-period.
//  Options     : TICK_PWM_CENTER_ALIGNED_EN - up/down (center-aligned)
//                counting, period of 2*(PERIOD-1) ticks. Edge-aligned when
//                undefined.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_pwm #(
    parameter int WIDTH  = 8,
    parameter int PERIOD = 100
) (
    input  logic        clk,
    input  logic        RE,
    tick_pwm_if.slave   bus
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(PERIOD - 1);

    logic             r_tick_q;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_duty_sh;
    logic             r_pwm;
    logic             r_period_end;
    logic             w_tick;

    // A tick is a rising edge of tick_in seen while counting is enabled;
    // edges arriving with CE low are dropped, not remembered.
    assign w_tick = bus.tick_in & ~r_tick_q & bus.CE;

`ifdef TICK_PWM_CENTER_ALIGNED_EN
    localparam logic [WIDTH-1:0] c_turn = WIDTH'(PERIOD - 2);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    dir_t r_dir;

    // Center-aligned counter: climbs to PERIOD-1, turns, descends to 0
    // where the period closes and the new duty is taken.
    always_ff @(posedge clk) begin
        if (!RE) begin
            r_tick_q     <= 1'b1;
            r_cnt        <= '0;
            r_duty_sh    <= '0;
            r_pwm        <= 1'b0;
            r_period_end <= 1'b0;
            r_dir        <= DIR_UP;
        end else begin
            r_tick_q     <= bus.tick_in;
            r_period_end <= 1'b0;
            r_pwm        <= (r_cnt < r_duty_sh);
            if (w_tick) begin
                if (r_dir == DIR_UP) begin
                    if (r_cnt == c_last) begin
                        r_cnt <= c_turn;
                        r_dir <= DIR_DOWN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    // cnt<=1 also covers PERIOD=2, where the turn lands on 0.
                    if (r_cnt <= WIDTH'(1)) begin
                        r_cnt        <= '0;
                        r_dir        <= DIR_UP;
                        r_duty_sh    <= bus.duty;
                        r_period_end <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            end
        end
    end
`else
    // Edge-aligned counter: 0..PERIOD-1 then wrap, loading the new duty
    // and flagging the period boundary on the wrapping tick.
    always_ff @(posedge clk) begin
        if (!RE) begin
            r_tick_q     <= 1'b1;
            r_cnt        <= '0;
            r_duty_sh    <= '0;
            r_pwm        <= 1'b0;
            r_period_end <= 1'b0;
        end else begin
            r_tick_q     <= bus.tick_in;
            r_period_end <= 1'b0;
            r_pwm        <= (r_cnt < r_duty_sh);
            if (w_tick) begin
                if (r_cnt == c_last) begin
                    r_cnt        <= '0;
                    r_duty_sh    <= bus.duty;
                    r_period_end <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end
`endif

    assign bus.pwm_out    = r_pwm;
    assign bus.cnt        = r_cnt;
    assign bus.period_end = r_period_end;

endmodule
`default_nettype wire

// File: tb/tb_tick_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tick_pwm
//  Description : Directed bench for tick_pwm (WIDTH=8, PERIOD=10). Each tick
//                is a 4-clk tick_in cycle (2 high, 2 low). Table rows give
//                the controls, a tick count and the expected counter, PWM,
//                number of period_end clks and number of PWM-high clks seen
//                over those ticks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tick_pwm;

    logic clk;
    logic RE;

    tick_pwm_if #(.WIDTH(8)) bus ();

    tick_pwm #(
        .WIDTH  (8),
        .PERIOD (10)
    ) dut (
        .clk (clk),
        .RE  (RE),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ce;
        logic [7:0] duty;
        int         ticks;
        int         exp_cnt;
        int         exp_pwm;
        int         exp_pe;
        int         exp_hi;
    } vec_t;

    vec_t tbl[20];
    int   n_vec;
    int   n_checks;
    int   n_errors;
    int   acc_pe;
    int   acc_hi;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clk, then sample 1 ns after the edge and accumulate activity.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus.period_end === 1'b1) acc_pe++;
        if (bus.pwm_out === 1'b1) acc_hi++;
    endtask

    task automatic do_tick();
        bus.tick_in = 1'b1;
        step();
        step();
        bus.tick_in = 1'b0;
        step();
        step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        acc_pe   = 0;
        acc_hi   = 0;
        n_vec    = 0;

`ifdef TICK_PWM_CENTER_ALIGNED_EN
        //                ce    duty   ticks cnt pwm pe  hi
        tbl[n_vec++] = '{1'b1, 8'd3,   8,    9,  0,  0,  0};
        tbl[n_vec++] = '{1'b1, 8'd3,   9,    0,  1,  1,  3};
        tbl[n_vec++] = '{1'b1, 8'd3,   18,   0,  1,  1,  20};
        tbl[n_vec++] = '{1'b0, 8'd3,   3,    0,  1,  0,  12};
        tbl[n_vec++] = '{1'b1, 8'd3,   2,    2,  1,  0,  8};
`else
        //                ce    duty    ticks cnt pwm pe  hi
        tbl[n_vec++] = '{1'b1, 8'd3,   9,    0,  1,  1,  3};
        tbl[n_vec++] = '{1'b1, 8'd3,   10,   0,  1,  1,  12};
        tbl[n_vec++] = '{1'b1, 8'd3,   5,    5,  0,  0,  9};
        tbl[n_vec++] = '{1'b1, 8'd7,   5,    0,  1,  1,  3};
        tbl[n_vec++] = '{1'b1, 8'd7,   10,   0,  1,  1,  28};
        tbl[n_vec++] = '{1'b1, 8'd0,   10,   0,  0,  1,  25};
        tbl[n_vec++] = '{1'b1, 8'd0,   10,   0,  0,  1,  0};
        tbl[n_vec++] = '{1'b1, 8'd10,  10,   0,  1,  1,  3};
        tbl[n_vec++] = '{1'b1, 8'd255, 10,   0,  1,  1,  40};
        tbl[n_vec++] = '{1'b1, 8'd255, 10,   0,  1,  1,  40};
        tbl[n_vec++] = '{1'b1, 8'd3,   10,   0,  1,  1,  40};
        tbl[n_vec++] = '{1'b1, 8'd3,   6,    6,  0,  0,  9};
        tbl[n_vec++] = '{1'b0, 8'd3,   20,   6,  0,  0,  0};
        tbl[n_vec++] = '{1'b1, 8'd3,   1,    7,  0,  0,  0};
        tbl[n_vec++] = '{1'b1, 8'd3,   3,    0,  1,  1,  3};
        tbl[n_vec++] = '{1'b0, 8'd3,   5,    0,  1,  0,  20};
        tbl[n_vec++] = '{1'b1, 8'd3,   8,    8,  0,  0,  9};
`endif

        // Reset held with tick_in high; release must not create a tick.
        RE          = 1'b0;
        bus.CE      = 1'b1;
        bus.tick_in = 1'b1;
        bus.duty    = 8'd0;
        repeat (5) step();
        check("reset_cnt", int'(bus.cnt), 0);
        check("reset_pwm", int'(bus.pwm_out), 0);
        check("reset_pe", int'(bus.period_end), 0);

        RE     = 1'b1;
        acc_pe = 0;
        repeat (3) step();
        check("release_no_edge_cnt", int'(bus.cnt), 0);
        check("release_no_edge_pe", acc_pe, 0);
        bus.tick_in = 1'b0;
        step();
        step();
        do_tick();
        check("first_tick_cnt", int'(bus.cnt), 1);

        for (int i = 0; i < n_vec; i++) begin
            bus.CE   = tbl[i].ce;
            bus.duty = tbl[i].duty;
            acc_pe   = 0;
            acc_hi   = 0;
            repeat (tbl[i].ticks) do_tick();
            check($sformatf("row%0d_cnt", i), int'(bus.cnt), tbl[i].exp_cnt);
            check($sformatf("row%0d_pwm", i), int'(bus.pwm_out), tbl[i].exp_pwm);
            check($sformatf("row%0d_pe_clks", i), acc_pe, tbl[i].exp_pe);
            check($sformatf("row%0d_hi_clks", i), acc_hi, tbl[i].exp_hi);
        end

        // Mid-period reset coinciding with a tick_in rising edge.
        bus.CE      = 1'b1;
        bus.duty    = 8'd3;
        bus.tick_in = 1'b1;
        RE          = 1'b0;
        step();
        check("midreset_cnt", int'(bus.cnt), 0);
        check("midreset_pwm", int'(bus.pwm_out), 0);
        check("midreset_pe", int'(bus.period_end), 0);
        RE          = 1'b1;
        bus.tick_in = 1'b0;
        step();
        step();
        acc_hi = 0;
        acc_pe = 0;
        do_tick();
        check("post_reset_cnt", int'(bus.cnt), 1);
        check("post_reset_duty_sh_cleared", acc_hi, 0);
        check("post_reset_pe", acc_pe, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
